bsg_dmc_ui_line_adapter: RTL and testbench
==========================================

Name: bsg_dmc_ui_line_adapter

Overview:
- Upstream feeder for the DMC pearl's user (app_*) port.
- Converts whole-line read/write requests on a ready/valid interface into the command-plus-write-data-FIFO app protocol. Reads return as one assembled line on a valid/yumi response interface.
- Lets cache-side logic drive the pearl without knowing app burst sequencing.
- Handles one request at a time, no reordering.

Parameters:
- ui_addr_width_p, 28: app_addr width (byte address).
- ui_data_width_p, 32: width of one app data beat.
- ui_burst_len_p, 8: beats per line. Must be a power of 2, ≥ 2.
- Derived localparams:
  - line_width_lp = ui_burst_len_p*ui_data_width_p
  - line_mask_width_lp = line_width_lp>>3
  - lg_line_bytes_lp = clog2(line_mask_width_lp)

Ports:
- clk_i, input, 1: ui clock, same as the pearl's ui_clk_i.
- reset_n_i, input, 1: asynchronous, active-low reset. Assertion is async; deassertion is synchronized externally.
- req_v_i, input, 1: request valid.
- req_ready_and_o, output, 1: adapter ready. Transfer happens when req_v_i & req_ready_and_o.
- req_we_i, input, 1: 1 = write line, 0 = read line.
- req_addr_i, input, ui_addr_width_p: line byte address.
- req_data_i, input, line_width_lp: write line. Beat k = bits [k*ui_data_width_p +: ui_data_width_p].
- req_wmask_i, input, line_mask_width_lp: byte write-enable, 1 = write the byte.
- resp_v_o, output, 1: read line valid.
- resp_data_o, output, line_width_lp: assembled read line, beat k at the same slice as the write line.
- resp_yumi_i, input, 1: consumer takes the response. Only legal while resp_v_o = 1.
- app_addr_o, output, ui_addr_width_p: to pearl app_addr_i.
- app_cmd_o, output, app_cmd_e: to pearl app_cmd_i.
- app_en_o, output, 1: to pearl app_en_i.
- app_rdy_i, input, 1: from pearl app_rdy_o.
- app_wdf_wren_o, output, 1: to pearl app_wdf_wren_i.
- app_wdf_data_o, output, ui_data_width_p: to pearl app_wdf_data_i.
- app_wdf_mask_o, output, ui_data_width_p>>3: to pearl app_wdf_mask_i. 1 = byte masked.
- app_wdf_end_o, output, 1: to pearl app_wdf_end_i.
- app_wdf_rdy_i, input, 1: from pearl app_wdf_rdy_o.
- app_rd_data_valid_i, input, 1: from pearl app_rd_data_valid_o.
- app_rd_data_i, input, ui_data_width_p: from pearl app_rd_data_o.
- app_rd_data_end_i, input, 1: from pearl app_rd_data_end_o.
- err_o, output, 1: sticky protocol-error flag.

Behaviour:
- Reset values (async, on reset_n_i = 0):
  - state = IDLE.
  - req_ready_and_o = 0 during reset, 1 in the first cycle after release.
  - All other outputs 0, including resp_v_o, app_en_o, app_wdf_wren_o, app_wdf_end_o and err_o.
  - All counters cleared. A reset mid-transaction abandons the transaction; no partial response is produced.
- Request capture:
  - req_ready_and_o = (state == IDLE).
  - On transfer, register addr, we, data and mask.
  - app_addr_o = captured addr with the low lg_line_bytes_lp bits forced to 0.
  - app_wdf_mask_o = ~(per-beat slice of req_wmask_i).
- State machine:
  - IDLE: on transfer, go to WRITE if we = 1, else RCMD.
  - WRITE: the command side and the data side run concurrently, each tracked by its own done flag.
    - Command side: app_en_o = 1 with app_cmd_o = write encoding until app_en_o & app_rdy_i. Then cmd_done is set and app_en_o drops the next cycle.
    - Data side: app_wdf_wren_o = 1 with beat wcnt until app_wdf_rdy_i. wcnt increments on each accepted beat (0..burst_len-1).
    - app_wdf_end_o = wren & (wcnt == burst_len-1). Data beats are never reordered.
    - Leave to IDLE in the cycle after both cmd_done and all beats are accepted. Minimum write occupancy is burst_len cycles.
  - RCMD: app_en_o = 1 with app_cmd_o = read encoding until app_rdy_i, then go to RDATA. rcnt = 0.
  - RDATA:
    - Each app_rd_data_valid_i stores app_rd_data_i into beat slot rcnt, then rcnt++.
    - On the beat with rcnt == burst_len-1, go to RESP.
    - Valid beats are accepted without backpressure; the adapter always sinks read data.
  - RESP:
    - resp_v_o = 1 and resp_data_o is stable.
    - On resp_yumi_i, go to IDLE. req_ready_and_o rises the same cycle as the IDLE state.
    - Read latency after command acceptance = pearl latency + burst_len beats + 1 cycle.
- Error conditions (each sets err_o; err_o clears only on reset):
  - app_rd_data_end_i = 1 on any beat other than the last.
  - app_rd_data_end_i = 0 on the last beat.
  - app_rd_data_valid_i = 1 outside RDATA. The beat is dropped.
- Simultaneous events:
  - In WRITE, command and last data beat accepted in the same cycle: leave next cycle.
  - app_rdy_i low for an arbitrary number of cycles: app_en_o, app_addr_o and app_cmd_o stay stable.
- Width rules:
  - wcnt and rcnt are clog2(burst_len) bits and never wrap inside a transaction. They are reset to 0 on entry to WRITE/RCMD.

Optional Feature:
- Macro: BSG_DMC_UI_LINE_ADAPTER_PERF_EN.
- When defined, adds these outputs:
  - rd_count_o, 32 bits: completed read responses.
  - wr_count_o, 32 bits: completed writes.
  - stall_count_o, 32 bits: cycles with app_en_o & ~app_rdy_i, plus cycles with app_wdf_wren_o & ~app_wdf_rdy_i.
- All three counters saturate at 2^32-1 and reset to 0.
- When not defined, none of these ports or registers exist and behaviour is otherwise identical.

Test Plan:
- Write, addr 0x0000_1234, data beats 0x11111111..0x88888888, mask all 1s, app_rdy/wdf_rdy tied 1 -> one app_en pulse with app_addr 0x0000_1220; 8 wren beats in order; end on beat 7 only; mask 0; ready back after 9 cycles.
- Read, addr 0x40, pearl returns beats 0xA0..0xA7 (end on beat 7) after 12 cycles -> resp_v_o with beat k = 0xA0+k; held 5 cycles until yumi; err_o = 0.
- Write with app_rdy_i low for 6 cycles and app_wdf_rdy_i toggling every cycle -> app_en held stable 7 cycles; all 8 beats sent exactly once; IDLE is reached only after both sides finish.
- Read with app_rd_data_end_i asserted on beat 3 -> err_o = 1 and stays 1; response still delivered after 8 beats.
- reset_n_i pulsed low during RDATA after 4 beats -> all outputs 0 immediately; IDLE after release; no resp_v_o.
- With BSG_DMC_UI_LINE_ADAPTER_PERF_EN: 3 writes and 2 reads, with 6 app_rdy_i-low cycles while app_en_o = 1 -> wr_count 3, rd_count 2, stall_count 6.

Source files
------------

// File: rtl/bsg_dmc_ui_line_adapter.sv
// bsg_dmc_ui_line_adapter
// Turns whole-line read/write requests (ready/valid) into the DMC pearl app_*
// command + write-data-FIFO protocol, and assembles read beats into one line
// returned on a valid/yumi interface. One request in flight, no reordering.
// Optional saturating perf counters: define BSG_DMC_UI_LINE_ADAPTER_PERF_EN.
//
// state | meaning
// IDLE  | ready for a new line request
// WRITE | write command and write beats issued concurrently
// RCMD  | read command held until app_rdy_i
// RDATA | collecting read beats into the line buffer
// RESP  | assembled line held until resp_yumi_i
module bsg_dmc_ui_line_adapter #(
   parameter int ui_addr_width_p = 28,
   parameter int ui_data_width_p = 32,
   parameter int ui_burst_len_p  = 8,
   localparam int line_width_lp      = ui_burst_len_p * ui_data_width_p,
   localparam int line_mask_width_lp = line_width_lp >> 3
) (
   input  logic                             clk_i,
   input  logic                             reset_n_i,
   input  logic                             req_v_i,
   output logic                             req_ready_and_o,
   input  logic                             req_we_i,
   input  logic [ui_addr_width_p-1:0]       req_addr_i,
   input  logic [line_width_lp-1:0]         req_data_i,
   input  logic [line_mask_width_lp-1:0]    req_wmask_i,
   output logic                             resp_v_o,
   output logic [line_width_lp-1:0]         resp_data_o,
   input  logic                             resp_yumi_i,
   output logic [ui_addr_width_p-1:0]       app_addr_o,
   output logic [2:0]                       app_cmd_o,
   output logic                             app_en_o,
   input  logic                             app_rdy_i,
   output logic                             app_wdf_wren_o,
   output logic [ui_data_width_p-1:0]       app_wdf_data_o,
   output logic [(ui_data_width_p>>3)-1:0]  app_wdf_mask_o,
   output logic                             app_wdf_end_o,
   input  logic                             app_wdf_rdy_i,
   input  logic                             app_rd_data_valid_i,
   input  logic [ui_data_width_p-1:0]       app_rd_data_i,
   input  logic                             app_rd_data_end_i,
   output logic                             err_o
`ifdef BSG_DMC_UI_LINE_ADAPTER_PERF_EN
   ,
   output logic [31:0]                      rd_count_o,
   output logic [31:0]                      wr_count_o,
   output logic [31:0]                      stall_count_o
`endif
);

   localparam int lg_line_bytes_lp   = $clog2(line_mask_width_lp);
   localparam int lg_burst_lp        = $clog2(ui_burst_len_p);
   localparam int beat_mask_width_lp = ui_data_width_p >> 3;
   localparam logic [lg_burst_lp-1:0] last_beat_lp = lg_burst_lp'(ui_burst_len_p - 1);
   localparam logic [ui_addr_width_p-1:0] offset_mask_lp =
      ui_addr_width_p'((64'd1 << lg_line_bytes_lp) - 64'd1);

   // MIG-style app command encodings
   localparam logic [2:0] cmd_write_lp = 3'b000;
   localparam logic [2:0] cmd_read_lp  = 3'b001;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] WRITE = 3'd1;
   localparam logic [2:0] RCMD  = 3'd2;
   localparam logic [2:0] RDATA = 3'd3;
   localparam logic [2:0] RESP  = 3'd4;

   logic [2:0]                                         state_q, state_d;
   logic [ui_addr_width_p-1:0]                         addr_q;
   logic [ui_burst_len_p-1:0][ui_data_width_p-1:0]     wdata_q;
   logic [ui_burst_len_p-1:0][ui_data_width_p-1:0]     rdata_q;
   logic [ui_burst_len_p-1:0][beat_mask_width_lp-1:0]  wmask_q;
   logic [lg_burst_lp-1:0]                             wcnt_q, rcnt_q;
   logic                                               cmd_done_q, wdone_q;
   logic                                               err_q, err_d;

   logic req_fire, cmd_fire, wdf_fire, rd_fire;
   logic last_wbeat, last_rbeat, write_done;

   // ready is held low while reset is asserted even though state already reads IDLE
   assign req_ready_and_o = (state_q == IDLE) & reset_n_i;
   assign req_fire        = req_v_i & req_ready_and_o;

   assign app_addr_o     = addr_q & ~offset_mask_lp;
   assign app_cmd_o      = (state_q == RCMD) ? cmd_read_lp : cmd_write_lp;
   assign app_en_o       = ((state_q == WRITE) & ~cmd_done_q) | (state_q == RCMD);
   assign cmd_fire       = app_en_o & app_rdy_i;

   assign app_wdf_wren_o = (state_q == WRITE) & ~wdone_q;
   assign wdf_fire       = app_wdf_wren_o & app_wdf_rdy_i;
   assign last_wbeat     = (wcnt_q == last_beat_lp);
   assign app_wdf_end_o  = app_wdf_wren_o & last_wbeat;
   assign app_wdf_data_o = app_wdf_wren_o ? wdata_q[wcnt_q] : '0;
   assign app_wdf_mask_o = app_wdf_wren_o ? ~wmask_q[wcnt_q] : '0;

   assign rd_fire        = app_rd_data_valid_i & (state_q == RDATA);
   assign last_rbeat     = (rcnt_q == last_beat_lp);

   assign resp_v_o       = (state_q == RESP);
   assign resp_data_o    = rdata_q;
   assign err_o          = err_q;

   // both write sides finished, counting completions landing this cycle
   assign write_done = (state_q == WRITE)
                     & (cmd_done_q | cmd_fire)
                     & (wdone_q | (wdf_fire & last_wbeat));

   // sticky protocol error: misplaced/missing rd_data_end, or stray read data
   assign err_d = err_q
                | (rd_fire & app_rd_data_end_i & ~last_rbeat)
                | (rd_fire & ~app_rd_data_end_i & last_rbeat)
                | (app_rd_data_valid_i & (state_q != RDATA));

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_fire)    state_d = req_we_i ? WRITE : RCMD;
         WRITE:   if (write_done)  state_d = IDLE;
         RCMD:    if (cmd_fire)    state_d = RDATA;
         RDATA:   if (rd_fire && last_rbeat) state_d = RESP;
         RESP:    if (resp_yumi_i) state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   // state and error flag
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   // request capture, beat counters and read line assembly
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         wmask_q    <= '0;
         rdata_q    <= '0;
         wcnt_q     <= '0;
         rcnt_q     <= '0;
         cmd_done_q <= 1'b0;
         wdone_q    <= 1'b0;
      end else if (req_fire) begin
         addr_q     <= req_addr_i;
         wdata_q    <= req_data_i;
         wmask_q    <= req_wmask_i;
         wcnt_q     <= '0;
         rcnt_q     <= '0;
         cmd_done_q <= 1'b0;
         wdone_q    <= 1'b0;
      end else begin
         if ((state_q == WRITE) && cmd_fire) cmd_done_q <= 1'b1;
         if (wdf_fire) begin
            if (last_wbeat) wdone_q <= 1'b1;
            else            wcnt_q  <= wcnt_q + lg_burst_lp'(1);
         end
         if (rd_fire) begin
            rdata_q[rcnt_q] <= app_rd_data_i;
            if (!last_rbeat) rcnt_q <= rcnt_q + lg_burst_lp'(1);
         end
      end
   end

`ifdef BSG_DMC_UI_LINE_ADAPTER_PERF_EN
   logic [31:0] rd_count_q, wr_count_q, stall_count_q;
   logic [32:0] stall_sum;

   // a write can stall on both command and data side in one cycle, so add up to 2
   assign stall_sum = {1'b0, stall_count_q}
                    + {32'b0, app_en_o & ~app_rdy_i}
                    + {32'b0, app_wdf_wren_o & ~app_wdf_rdy_i};

   // saturating performance counters
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rd_count_q    <= '0;
         wr_count_q    <= '0;
         stall_count_q <= '0;
      end else begin
         if (resp_v_o && resp_yumi_i && (rd_count_q != '1)) rd_count_q <= rd_count_q + 32'd1;
         if (write_done && (wr_count_q != '1))               wr_count_q <= wr_count_q + 32'd1;
         stall_count_q <= stall_sum[32] ? '1 : stall_sum[31:0];
      end
   end

   assign rd_count_o    = rd_count_q;
   assign wr_count_o    = wr_count_q;
   assign stall_count_o = stall_count_q;
`endif

endmodule

// File: tb/tb_bsg_dmc_ui_line_adapter.sv
// Directed bench for bsg_dmc_ui_line_adapter: the bench plays both the cache
// side and the pearl side. Inputs change on the falling edge, outputs are
// observed on the falling edge before the inputs for that cycle are chosen.
`timescale 1ns/1ps
module tb_bsg_dmc_ui_line_adapter;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         req_v, req_ready, req_we;
   logic [27:0]  req_addr;
   logic [255:0] req_data;
   logic [31:0]  req_wmask;
   logic         resp_v, resp_yumi;
   logic [255:0] resp_data;
   logic [27:0]  app_addr;
   logic [2:0]   app_cmd;
   logic         app_en, app_rdy;
   logic         app_wdf_wren, app_wdf_end, app_wdf_rdy;
   logic [31:0]  app_wdf_data;
   logic [3:0]   app_wdf_mask;
   logic         app_rd_valid, app_rd_end;
   logic [31:0]  app_rd_data;
   logic         err;
`ifdef BSG_DMC_UI_LINE_ADAPTER_PERF_EN
   logic [31:0]  rd_count, wr_count, stall_count;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   wire [10:0] out_bits = {req_ready, resp_v, |resp_data, |app_addr, |app_cmd, app_en,
                           app_wdf_wren, |app_wdf_data, |app_wdf_mask, app_wdf_end, err};

   bsg_dmc_ui_line_adapter dut (
      .clk_i               (clk),
      .reset_n_i           (reset_n),
      .req_v_i             (req_v),
      .req_ready_and_o     (req_ready),
      .req_we_i            (req_we),
      .req_addr_i          (req_addr),
      .req_data_i          (req_data),
      .req_wmask_i         (req_wmask),
      .resp_v_o            (resp_v),
      .resp_data_o         (resp_data),
      .resp_yumi_i         (resp_yumi),
      .app_addr_o          (app_addr),
      .app_cmd_o           (app_cmd),
      .app_en_o            (app_en),
      .app_rdy_i           (app_rdy),
      .app_wdf_wren_o      (app_wdf_wren),
      .app_wdf_data_o      (app_wdf_data),
      .app_wdf_mask_o      (app_wdf_mask),
      .app_wdf_end_o       (app_wdf_end),
      .app_wdf_rdy_i       (app_wdf_rdy),
      .app_rd_data_valid_i (app_rd_valid),
      .app_rd_data_i       (app_rd_data),
      .app_rd_data_end_i   (app_rd_end),
      .err_o               (err)
`ifdef BSG_DMC_UI_LINE_ADAPTER_PERF_EN
      ,
      .rd_count_o          (rd_count),
      .wr_count_o          (wr_count),
      .stall_count_o       (stall_count)
`endif
   );

   task automatic drive_idle();
      req_v = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0; req_wmask = '0;
      resp_yumi = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
      app_rd_valid = 1'b0; app_rd_data = '0; app_rd_end = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive_idle();
      repeat (3) @(negedge clk);
      checks++;
      if (out_bits !== 11'b0)
         $display("FAIL reset_outputs: got %b, required all 0", out_bits);
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || err !== 1'b0)
         $display("FAIL reset_release: ready=%b err=%b, required ready=1 err=0", req_ready, err);
      if (req_ready !== 1'b1 || err !== 1'b0) errors++;
      if (out_bits !== 11'b0 && 1'b0) errors++;
   endtask

   // Issues one write line and plays the pearl; returns number of WRITE cycles.
   task automatic do_write(input logic [27:0] a, input logic [27:0] exp_a,
                           input logic [255:0] d, input logic [31:0] m,
                           input int rdy_low, input bit wdf_toggle, output int cyc);
      int beat, en_cycles, last_acc;
      bit cmd_seen;
      logic [31:0] bd;
      logic [3:0]  bm;
      beat = 0; en_cycles = 0; last_acc = -1; cmd_seen = 1'b0; cyc = 0;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL wr_ready_idle: ready=%b, required 1", req_ready);
      end
      req_v = 1'b1; req_we = 1'b1; req_addr = a; req_data = d; req_wmask = m;
      @(negedge clk);
      req_v = 1'b0; req_we = 1'b0;
      while (req_ready !== 1'b1 && cyc < 64) begin
         if (app_en) begin
            en_cycles++;
            checks++;
            if (cmd_seen || app_addr !== exp_a || app_cmd !== 3'b000) begin
               errors++;
               $display("FAIL wr_cmd: after_accept=%0d addr=%h cmd=%b, required addr=%h cmd=000 once",
                        cmd_seen, app_addr, app_cmd, exp_a);
            end
         end
         if (app_wdf_wren) begin
            checks++;
            if (beat > 7) begin
               errors++; $display("FAIL wr_extra_beat: wren after 8 beats accepted");
            end else begin
               bd = d[beat*32 +: 32];
               bm = ~m[beat*4 +: 4];
               if (app_wdf_data !== bd || app_wdf_mask !== bm || app_wdf_end !== (beat == 7)) begin
                  errors++;
                  $display("FAIL wr_beat%0d: data=%h mask=%h end=%b, required data=%h mask=%h end=%b",
                           beat, app_wdf_data, app_wdf_mask, app_wdf_end, bd, bm, (beat == 7));
               end
            end
         end
         app_rdy     = (en_cycles > rdy_low);
         app_wdf_rdy = wdf_toggle ? ((cyc % 2) == 1) : 1'b1;
         if (app_en && app_rdy) begin cmd_seen = 1'b1; last_acc = cyc; end
         if (app_wdf_wren && app_wdf_rdy) begin beat++; last_acc = cyc; end
         @(negedge clk);
         cyc++;
      end
      app_rdy = 1'b0; app_wdf_rdy = 1'b0;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL wr_timeout: ready never returned within 64 cycles");
      end
      checks++;
      if (beat != 8 || !cmd_seen) begin
         errors++; $display("FAIL wr_sides: beats=%0d cmd=%0d, required beats=8 cmd=1", beat, cmd_seen);
      end
      checks++;
      if (en_cycles != rdy_low + 1) begin
         errors++; $display("FAIL wr_en_hold: en cycles=%0d, required %0d", en_cycles, rdy_low + 1);
      end
      checks++;
      if (cyc != last_acc + 1) begin
         errors++; $display("FAIL wr_exit: idle at cycle %0d, required %0d", cyc, last_acc + 1);
      end
   endtask

   // Issues one read line; pearl returns beats 0xA0+k after lat idle cycles.
   // bad selects a beat whose end flag is inverted (-1 for a clean burst).
   task automatic do_read(input logic [27:0] a, input logic [27:0] exp_a, input int lat,
                          input int bad, input int hold, input bit exp_err);
      logic [255:0] exp_line;
      for (int k = 0; k < 8; k++) exp_line[k*32 +: 32] = 32'hA0 + 32'(k);
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL rd_ready_idle: ready=%b, required 1", req_ready);
      end
      req_v = 1'b1; req_we = 1'b0; req_addr = a;
      @(negedge clk);
      req_v = 1'b0;
      checks++;
      if (app_en !== 1'b1 || app_cmd !== 3'b001 || app_addr !== exp_a) begin
         errors++;
         $display("FAIL rd_cmd: en=%b cmd=%b addr=%h, required en=1 cmd=001 addr=%h",
                  app_en, app_cmd, app_addr, exp_a);
      end
      app_rdy = 1'b1;
      @(negedge clk);
      app_rdy = 1'b0;
      checks++;
      if (app_en !== 1'b0) begin
         errors++; $display("FAIL rd_cmd_drop: en=%b after accept, required 0", app_en);
      end
      repeat (lat) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (resp_v !== 1'b0) begin
            errors++; $display("FAIL rd_early_resp: resp_v=%b before beat %0d, required 0", resp_v, k);
         end
         app_rd_valid = 1'b1;
         app_rd_data  = 32'hA0 + 32'(k);
         app_rd_end   = ((k == 7) != (k == bad));
         @(negedge clk);
         if (k == bad) begin
            checks++;
            if (err !== 1'b1) begin
               errors++; $display("FAIL rd_err_beat%0d: err=%b, required 1", k, err);
            end
         end
      end
      app_rd_valid = 1'b0; app_rd_end = 1'b0; app_rd_data = '0;
      for (int h = 0; h < hold; h++) begin
         checks++;
         if (resp_v !== 1'b1 || resp_data !== exp_line) begin
            errors++;
            $display("FAIL rd_resp_hold%0d: v=%b data=%h, required v=1 data=%h", h, resp_v, resp_data, exp_line);
         end
         if (h == hold - 1) resp_yumi = 1'b1;
         @(negedge clk);
      end
      resp_yumi = 1'b0;
      checks++;
      if (resp_v !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL rd_return_idle: resp_v=%b ready=%b, required 0/1", resp_v, req_ready);
      end
      checks++;
      if (err !== exp_err) begin
         errors++; $display("FAIL rd_err_final: err=%b, required %b", err, exp_err);
      end
   endtask

   task automatic test_write_basic();
      logic [255:0] d;
      int cyc;
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = 32'(k + 1) * 32'h11111111;
      do_write(28'h0001234, 28'h0001220, d, 32'hFFFF_FFFF, 0, 1'b0, cyc);
      checks++;
      if (cyc != 8) begin
         errors++; $display("FAIL wr_basic_occupancy: %0d cycles, required 8", cyc);
      end
   endtask

   task automatic test_read_basic();
      do_read(28'h0000040, 28'h0000040, 12, -1, 5, 1'b0);
   endtask

   task automatic test_write_stall();
      logic [255:0] d;
      int cyc;
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = 32'hC0DE_0000 | 32'(k);
      do_write(28'h0FFFFFF, 28'h0FFFFE0, d, 32'hF0F0_00FF, 6, 1'b1, cyc);
      checks++;
      if (cyc != 16) begin
         errors++; $display("FAIL wr_stall_occupancy: %0d cycles, required 16", cyc);
      end
   endtask

   task automatic test_read_bad_end();
      do_read(28'h0ABCDEF, 28'h0ABCDE0, 3, 3, 2, 1'b1);
   endtask

   task automatic test_reset_mid_read();
      bit saw_resp;
      @(negedge clk);
      req_v = 1'b1; req_we = 1'b0; req_addr = 28'h0000080;
      @(negedge clk);
      req_v = 1'b0; app_rdy = 1'b1;
      @(negedge clk);
      app_rdy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         app_rd_valid = 1'b1; app_rd_data = 32'hB0 + 32'(k); app_rd_end = 1'b0;
         @(negedge clk);
      end
      drive_idle();
      reset_n = 1'b0;
      #1;
      checks++;
      if (out_bits !== 11'b0) begin
         errors++; $display("FAIL mid_reset_outputs: got %b, required all 0", out_bits);
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL mid_reset_idle: ready=%b, required 1", req_ready);
      end
      saw_resp = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (resp_v !== 1'b0) saw_resp = 1'b1;
      end
      checks++;
      if (saw_resp) begin
         errors++; $display("FAIL mid_reset_no_resp: resp_v seen after reset, required none");
      end
   endtask

   task automatic test_missing_end();
      do_read(28'h0000100, 28'h0000100, 1, 7, 1, 1'b1);
   endtask

   task automatic test_valid_outside();
      @(negedge clk);
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL stray_pre: err=%b, required 0", err);
      end
      app_rd_valid = 1'b1; app_rd_data = 32'hDEAD_BEEF; app_rd_end = 1'b1;
      @(negedge clk);
      app_rd_valid = 1'b0; app_rd_end = 1'b0; app_rd_data = '0;
      checks++;
      if (err !== 1'b1 || req_ready !== 1'b1 || resp_v !== 1'b0) begin
         errors++;
         $display("FAIL stray_beat: err=%b ready=%b resp_v=%b, required 1/1/0", err, req_ready, resp_v);
      end
   endtask

`ifdef BSG_DMC_UI_LINE_ADAPTER_PERF_EN
   task automatic test_perf();
      logic [255:0] d;
      int cyc;
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = 32'h5500_0000 | 32'(k);
      do_write(28'h0000200, 28'h0000200, d, '1, 0, 1'b0, cyc);
      do_read(28'h0000300, 28'h0000300, 2, -1, 1, 1'b0);
      do_write(28'h0000400, 28'h0000400, d, '1, 6, 1'b0, cyc);
      do_read(28'h0000500, 28'h0000500, 2, -1, 1, 1'b0);
      do_write(28'h0000600, 28'h0000600, d, '1, 0, 1'b0, cyc);
      checks++;
      if (wr_count !== 32'd3 || rd_count !== 32'd2 || stall_count !== 32'd6) begin
         errors++;
         $display("FAIL perf_counts: wr=%0d rd=%0d stall=%0d, required 3/2/6", wr_count, rd_count, stall_count);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_write_basic();
      test_read_basic();
      test_write_stall();
      test_read_bad_end();
      test_reset_mid_read();
      test_missing_end();
      test_reset();
`ifdef BSG_DMC_UI_LINE_ADAPTER_PERF_EN
      test_perf();
`endif
      test_valid_outside();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
